// File: rtl/mux_scan_ctrl.sv
// Select sequencer for the mux8x1 stage: steps sel through every channel, waits
// a settle time on each, samples mux_o and publishes the assembled word with a done pulse.
module mux_scan_ctrl #(
   parameter int N_CH   = 8,
   parameter int SEL_W  = 3,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             mux_o,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             done,
   output logic [N_CH-1:0]  data_out
);

   // state      | meaning
   // ST_IDLE    | waiting for start, sel parked at 0
   // ST_SETTLE  | sel held while the mux path settles (SETTLE cycles)
   // ST_SAMPLE  | capture mux_o for the current channel, advance or finish
   // ST_DONE    | one-cycle done pulse, start ignored
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N_CH - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [N_CH-1:0]  data_q, data_d;
   logic [N_CH-1:0]  cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         cap_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         data_q  <= data_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      data_d  = data_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            sel_d  = '0;
            busy_d = 1'b0;
            if (start && !abort) begin
               busy_d  = 1'b1;
               cnt_d   = CNT_LOAD;
               cap_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               busy_d  = 1'b0;
               sel_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               busy_d  = 1'b0;
               sel_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cap_d[sel_q] = mux_o;
               if (sel_q == SEL_LAST) begin
                  // cap_d already carries the last bit, so the word lands whole
                  data_d  = cap_d;
                  busy_d  = 1'b0;
                  sel_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  sel_d   = sel_q + 1'b1;
                  cnt_d   = CNT_LOAD;
                  state_d = ST_SETTLE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign sel      = sel_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_q;

endmodule
